mem_wb_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register. Takes the registered EX-stage result and control, runs the data-memory access over a req/gnt/rvalid bus, aligns load and store data, and drives the register-file writeback port.
- Raises a stall back toward the EX/MEM register and earlier stages while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_wb_stage_if.sv | 24 ++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_wb_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory/writeback stage.
// Access size codes, FSM states and a misalignment helper.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_B = 3'b000,
    MEM_H = 3'b001,
    MEM_W = 3'b010
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } mem_fsm_e;

  // Any code other than B/H is handled as a word access.
  function automatic logic misaligned(
    input logic [2:0] sz,
    input logic [1:0] lo
  );
    if (sz == MEM_B) return 1'b0;
    if (sz == MEM_H) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/gnt/rvalid bus.
// master = pipeline stage, slave = memory.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-lane steering and load extract/extend.
// Purely combinational; store and load paths are independent.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;
  logic        sgn_b;
  logic        sgn_h;

  // Store: replicate data across lanes, enable the addressed ones.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      MEM_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_H: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};
  assign sgn_b   = ~ld_unsigned_i & shifted[7];
  assign sgn_h   = ~ld_unsigned_i & shifted[15];

  // Load: shift addressed lane down, then sign/zero extend.
  always_comb begin
    ld_data_o = shifted;
    case (ld_size_i)
      MEM_B:   ld_data_o = {{24{sgn_b}}, shifted[7:0]};
      MEM_H:   ld_data_o = {{16{sgn_h}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access and register writeback stage.
// Build option MISALIGN_TRAP_EN adds trap_o for misaligned H/W.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rdata2_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic [4:0]  rd_i,
  input  logic        rf_en_i,
  input  logic        mem_write_i,
  input  logic        is_load_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  load_type_i,
  input  logic        load_unsigned_i,
  input  logic [2:0]  store_type_i,
  output logic        stall_o,
  mem_wb_stage_if.master dmem,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        trap_o
`endif
);

  mem_fsm_e          state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic              rf_en_q, rf_en_d;
  logic [2:0]        lsize_q, lsize_d;
  logic              lu_q, lu_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;

  logic              mem_op;
  logic [2:0]        size;
  logic              mis;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;

  assign mem_op = valid_i & (is_load_i | mem_write_i);
  assign size   = is_load_i ? load_type_i : store_type_i;

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  assign mis    = misaligned(size, alu_result_i[1:0]);
  assign trap_d = (state_q == IDLE) & mem_op & mis;
  assign trap_o = trap_q;

  // One-cycle trap pulse for a rejected misaligned access.
  always_ff @(posedge clk) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end
`else
  assign mis = 1'b0;
`endif

  mem_lane_align u_align (
    .st_size_i     (store_type_i),
    .st_off_i      (alu_result_i[1:0]),
    .st_data_i     (rdata2_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (lsize_q),
    .ld_off_i      (addr_q[1:0]),
    .ld_unsigned_i (lu_q),
    .ld_rdata_i    (dmem.rdata),
    .ld_data_o     (ld_data)
  );

  // Next state, access capture, writeback and stall.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    rf_en_d   = rf_en_q;
    lsize_d   = lsize_q;
    lu_d      = lu_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    stall_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!mis) begin
            addr_d  = alu_result_i[ADDR_W-1:0];
            be_d    = st_be;
            wdata_d = st_wdata;
            we_d    = ~is_load_i;
            rd_d    = rd_i;
            rf_en_d = rf_en_i;
            lsize_d = load_type_i;
            lu_d    = load_unsigned_i;
            stall_o = 1'b1;
            state_d = REQ;
          end
        end else if (valid_i) begin
          wb_en_d   = rf_en_i & (rd_i != 5'd0);
          wb_rd_d   = rd_i;
          wb_data_d = (is_jal_i | is_jalr_i) ? pc_plus_4_i
                                             : alu_result_i;
        end
      end
      REQ: begin
        stall_o = ~(dmem.gnt & we_q);
        if (dmem.gnt) state_d = we_q ? IDLE : RSP;
      end
      RSP: begin
        stall_o = ~dmem.rvalid;
        if (dmem.rvalid) begin
          state_d   = IDLE;
          wb_en_d   = rf_en_q & (rd_q != 5'd0);
          wb_rd_d   = rd_q;
          wb_data_d = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured access registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      rf_en_q   <= 1'b0;
      lsize_q   <= '0;
      lu_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      rf_en_q   <= rf_en_d;
      lsize_q   <= lsize_d;
      lu_q      <= lu_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  assign wb_en_o   = wb_en_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed + random checks against a behavioural model.
// Define MISALIGN_TRAP_EN to also exercise trap_o.
module tb_mem_wb_stage;

  localparam int K_ALU  = 0;
  localparam int K_LD   = 1;
  localparam int K_ST   = 2;
  localparam int K_JAL  = 3;
  localparam int K_JALR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] rdata2_i;
  logic [31:0] pc_plus_4_i;
  logic [4:0]  rd_i;
  logic        rf_en_i;
  logic        mem_write_i;
  logic        is_load_i;
  logic        is_jal_i;
  logic        is_jalr_i;
  logic [2:0]  load_type_i;
  logic        load_unsigned_i;
  logic [2:0]  store_type_i;
  logic        stall_o;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
`ifdef MISALIGN_TRAP_EN
  logic        trap_o;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(32)) dmem ();

  mem_wb_stage #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .alu_result_i    (alu_result_i),
    .rdata2_i        (rdata2_i),
    .pc_plus_4_i     (pc_plus_4_i),
    .rd_i            (rd_i),
    .rf_en_i         (rf_en_i),
    .mem_write_i     (mem_write_i),
    .is_load_i       (is_load_i),
    .is_jal_i        (is_jal_i),
    .is_jalr_i       (is_jalr_i),
    .load_type_i     (load_type_i),
    .load_unsigned_i (load_unsigned_i),
    .store_type_i    (store_type_i),
    .stall_o         (stall_o),
    .dmem            (dmem),
    .wb_en_o         (wb_en_o),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .trap_o          (trap_o)
`endif
  );

  function automatic logic [3:0] m_be(logic [2:0] sz, logic [1:0] off);
    if (sz == 3'd0) return 4'(1 << off);
    if (sz == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] sz, logic [31:0] d);
    if (sz == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] sz, logic [1:0] off,
                                         logic u, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (sz == 3'd0) begin
      v = v & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 3'd1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic m_trap(logic [2:0] sz, logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
    if (sz == 3'd0) return 1'b0;
    if (sz == 3'd1) return off[0];
    return off != 2'b00;
`else
    return 1'b0 & sz[0] & off[0];
`endif
  endfunction

  task automatic idle_inputs();
    valid_i = 0; mem_write_i = 0; is_load_i = 0;
    is_jal_i = 0; is_jalr_i = 0; rf_en_i = 0;
    dmem.gnt = 0; dmem.rvalid = 0;
  endtask

  task automatic do_instr(input int kind, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] pc4,
                          input logic [4:0] rd, input logic rfen,
                          input logic [2:0] sz, input logic uns,
                          input int gdly, input int rvdly,
                          input logic [31:0] rdata);
    logic mem, trap, st, granted, done, exp_stall, ewb;
    logic [31:0] edata;
    int gcnt, rcnt, cyc;
    mem  = (kind == K_LD) || (kind == K_ST);
    st   = (kind == K_ST);
    trap = mem && m_trap(sz, addr[1:0]);
    @(posedge clk); #1;
    valid_i = 1; alu_result_i = addr; rdata2_i = rs2;
    pc_plus_4_i = pc4; rd_i = rd; rf_en_i = rfen;
    mem_write_i = st; is_load_i = (kind == K_LD);
    is_jal_i = (kind == K_JAL); is_jalr_i = (kind == K_JALR);
    load_type_i = sz; store_type_i = sz; load_unsigned_i = uns;
    dmem.gnt = 0; dmem.rvalid = 0;
    gcnt = 0; rcnt = 0; cyc = 0; granted = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      dmem.gnt = 0; dmem.rvalid = 0;
      vecs++;
      if (wb_en_o !== 1'b0) begin
        errs++; $display("FAIL wb_busy: wb_en_o=%b want 0", wb_en_o);
      end
      if (!granted) begin
        if (dmem.req === 1'b1) begin
          vecs++;
          if (!mem || trap) begin
            errs++; $display("FAIL spurious_req: req=1 want 0");
          end else if ({dmem.addr, dmem.we, dmem.be, dmem.wdata} !==
                       {addr & 32'hFFFF_FFFC, st, m_be(sz, addr[1:0]),
                        m_wdata(sz, rs2)}) begin
            errs++;
            $display("FAIL req_fields: addr=%h we=%b be=%b wd=%h want %h %b %b %h",
                     dmem.addr, dmem.we, dmem.be, dmem.wdata,
                     addr & 32'hFFFF_FFFC, st, m_be(sz, addr[1:0]),
                     m_wdata(sz, rs2));
          end
          if (gcnt == gdly) begin dmem.gnt = 1; granted = 1; end
          gcnt++;
        end
      end else if (!st) begin
        rcnt++;
        vecs++;
        if (dmem.req !== 1'b0) begin
          errs++; $display("FAIL req_in_rsp: req=%b want 0", dmem.req);
        end
        if (rcnt >= rvdly) begin dmem.rvalid = 1; dmem.rdata = rdata; end
      end
      #1;
      exp_stall = mem && !trap && !((dmem.gnt && st) || dmem.rvalid);
      vecs++;
      if (stall_o !== exp_stall) begin
        errs++;
        $display("FAIL stall: cyc %0d got %b want %b", cyc, stall_o, exp_stall);
      end
      if (!exp_stall) done = 1;
    end
    if (!done) begin
      errs++; $display("FAIL timeout: access did not complete");
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    ewb = !trap && !st && rfen && (rd != 5'd0);
    if (kind == K_LD)
      edata = m_load(sz, addr[1:0], uns, rdata);
    else if (kind == K_JAL || kind == K_JALR)
      edata = pc4;
    else
      edata = addr;
    vecs++;
    if (wb_en_o !== ewb) begin
      errs++; $display("FAIL wb_en: got %b want %b", wb_en_o, ewb);
    end
    if (ewb) begin
      vecs++;
      if ({wb_rd_o, wb_data_o} !== {rd, edata}) begin
        errs++;
        $display("FAIL wb_data: rd %0d data %h want rd %0d data %h",
                 wb_rd_o, wb_data_o, rd, edata);
      end
    end
`ifdef MISALIGN_TRAP_EN
    vecs++;
    if (trap_o !== trap) begin
      errs++; $display("FAIL trap: got %b want %b", trap_o, trap);
    end
`endif
    @(negedge clk);
    vecs++;
    if (wb_en_o !== 1'b0) begin
      errs++; $display("FAIL wb_pulse: wb_en_o=%b want 0", wb_en_o);
    end
`ifdef MISALIGN_TRAP_EN
    vecs++;
    if (trap_o !== 1'b0) begin
      errs++; $display("FAIL trap_pulse: got %b want 0", trap_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    alu_result_i = 0; rdata2_i = 0; pc_plus_4_i = 0; rd_i = 0;
    load_type_i = 0; store_type_i = 0; load_unsigned_i = 0;
    dmem.rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({stall_o, dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be,
         wb_en_o, wb_rd_o, wb_data_o} !== '0) begin
      errs++;
      $display("FAIL reset: stall %b req %b addr %h be %b wb %b/%0d/%h want 0",
               stall_o, dmem.req, dmem.addr, dmem.be,
               wb_en_o, wb_rd_o, wb_data_o);
    end
    #1 rst_n = 1;
  endtask

  task automatic test_store();
    do_instr(K_ST, 32'h100, 32'hDEADBEEF, 0, 5'd3, 1'b0, 3'd2, 0, 2, 1, 0);
    do_instr(K_ST, 32'h203, 32'h0000_00A5, 0, 5'd3, 1'b1, 3'd0, 0, 0, 1, 0);
    do_instr(K_ST, 32'h302, 32'h1234_5678, 0, 5'd0, 1'b0, 3'd1, 0, 1, 1, 0);
  endtask

  task automatic test_load();
    do_instr(K_LD, 32'h102, 0, 0, 5'd5, 1'b1, 3'd0, 1'b0, 0, 1, 32'h12F45678);
    do_instr(K_LD, 32'h102, 0, 0, 5'd5, 1'b1, 3'd0, 1'b1, 1, 2, 32'h12F45678);
    do_instr(K_LD, 32'h102, 0, 0, 5'd7, 1'b1, 3'd1, 1'b0, 0, 1, 32'h80010000);
    do_instr(K_LD, 32'h102, 0, 0, 5'd7, 1'b1, 3'd1, 1'b1, 2, 1, 32'h80010000);
    do_instr(K_LD, 32'h102, 0, 0, 5'd0, 1'b1, 3'd1, 1'b0, 0, 1, 32'h80010000);
    do_instr(K_LD, 32'h400, 0, 0, 5'd9, 1'b1, 3'd2, 1'b0, 0, 3, 32'hCAFEF00D);
  endtask

  task automatic test_jal();
    do_instr(K_JAL, 32'h0000_0800, 0, 32'h44, 5'd1, 1'b1, 3'd0, 0, 0, 1, 0);
    do_instr(K_JALR, 32'h0000_0900, 0, 32'h88, 5'd2, 1'b1, 3'd0, 0, 0, 1, 0);
    do_instr(K_ALU, 32'h1357_9BDF, 0, 32'h88, 5'd4, 1'b1, 3'd0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_rsp();
    int cyc;
    @(posedge clk); #1;
    valid_i = 1; is_load_i = 1; mem_write_i = 0;
    alu_result_i = 32'h500; rd_i = 5'd6; rf_en_i = 1;
    load_type_i = 3'd2; load_unsigned_i = 0;
    cyc = 0;
    @(negedge clk);
    while (dmem.req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    vecs++;
    if (dmem.req !== 1'b1) begin
      errs++; $display("FAIL rst_req: req=%b want 1", dmem.req);
    end
    dmem.gnt = 1;
    @(negedge clk);
    dmem.gnt = 0;
    #1;
    vecs++;
    if (stall_o !== 1'b1) begin
      errs++; $display("FAIL rst_rsp_stall: got %b want 1", stall_o);
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    dmem.rvalid = 1; dmem.rdata = 32'h7777_7777;
    #1;
    vecs++;
    if ({stall_o, dmem.req} !== 2'b00) begin
      errs++;
      $display("FAIL rst_idle: stall %b req %b want 0 0", stall_o, dmem.req);
    end
    @(posedge clk); #1;
    dmem.rvalid = 0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (wb_en_o !== 1'b0) begin
        errs++; $display("FAIL rst_late_rvalid: wb_en_o=%b want 0", wb_en_o);
      end
    end
  endtask

  task automatic test_trap();
`ifdef MISALIGN_TRAP_EN
    do_instr(K_LD, 32'h102, 0, 0, 5'd5, 1'b1, 3'd2, 0, 0, 1, 32'h1111_1111);
    do_instr(K_ST, 32'h101, 32'hABCD, 0, 5'd0, 1'b0, 3'd1, 0, 0, 1, 0);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      do_instr($urandom_range(0, 4), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_jal();
    test_reset_mid_rsp();
    test_trap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
